// File: rtl/ovi_issue_ctrl.sv
// ovi_issue_ctrl: issue scheduler between the SweRV core and the OVI vector unit.
// Allocates scoreboard ids, meters issue against VPU credits, drives a registered
// OVI issue beat and returns VPU completions to the core one cycle later.

`ifndef OVI_INSTR_WIDTH
`define OVI_INSTR_WIDTH 32
`endif
`ifndef OVI_SCALAROPND_WIDTH
`define OVI_SCALAROPND_WIDTH 32
`endif
`ifndef OVI_SBID_WIDTH
`define OVI_SBID_WIDTH 5
`endif
`ifndef OVI_VL_WIDTH
`define OVI_VL_WIDTH 15
`endif
`ifndef OVI_VSTART_WIDTH
`define OVI_VSTART_WIDTH 14
`endif
`ifndef OVI_SEW_WIDTH
`define OVI_SEW_WIDTH 3
`endif
`ifndef OVI_DATA_WIDTH
`define OVI_DATA_WIDTH 32
`endif

module ovi_issue_ctrl #(
    parameter int unsigned CREDITS         = 4,
    parameter int unsigned MAX_OUTSTANDING = 8
) (
    input  logic                              clk,
    input  logic                              rst_l,
    input  logic [`OVI_INSTR_WIDTH-1:0]       core_instr,
    input  logic [`OVI_VL_WIDTH-1:0]          core_vl,
    input  logic [`OVI_SEW_WIDTH-1:0]         core_sew,
    input  logic [`OVI_SCALAROPND_WIDTH-1:0]  core_scalar,
    input  logic                              core_valid,
    output logic                              core_ready,
    input  logic [1:0]                        cfg_vlmul,
    input  logic [2:0]                        cfg_frm,
    input  logic [1:0]                        cfg_vxrm,
    output logic [`OVI_INSTR_WIDTH-1:0]       vpu_instr,
    output logic [`OVI_SCALAROPND_WIDTH-1:0]  vpu_scalar_opnd,
    output logic [`OVI_SBID_WIDTH-1:0]        vpu_sb_id,
    output logic [`OVI_SEW_WIDTH-1:0]         vpu_vsew,
    output logic [1:0]                        vpu_vlmul,
    output logic [2:0]                        vpu_frm,
    output logic [1:0]                        vpu_vxrm,
    output logic [`OVI_VL_WIDTH-1:0]          vpu_vl,
    output logic [`OVI_VSTART_WIDTH-1:0]      vpu_vstart,
    output logic                              vpu_vill,
    output logic                              vpu_valid,
    input  logic                              vpu_credit,
    input  logic                              cmp_valid,
    input  logic [`OVI_SBID_WIDTH-1:0]        cmp_sb_id,
    input  logic [`OVI_SCALAROPND_WIDTH-1:0]  cmp_dest_reg,
    input  logic                              cmp_illegal,
    output logic [`OVI_DATA_WIDTH-1:0]        core_cmp_data,
    output logic                              core_cmp_valid,
    output logic                              core_cmp_illegal,
    output logic [1:0]                        err_sticky
);

    localparam int unsigned NUM_IDS = 1 << `OVI_SBID_WIDTH;
    localparam int unsigned CNT_W   = $clog2(CREDITS + 1);
    localparam int unsigned OUT_W   = $clog2(MAX_OUTSTANDING + 1);

    logic [CNT_W-1:0]           cnt;
    logic [NUM_IDS-1:0]         busy;
    logic [OUT_W-1:0]           out_cnt;
    logic [`OVI_SBID_WIDTH-1:0] next_id;
    logic                       accept;
    logic                       cmp_hit;
    logic                       cmp_miss;

    // Issue is allowed only with a credit, room in the outstanding cap and a free next id.
    assign core_ready = rst_l && (cnt != '0) && (32'(out_cnt) < MAX_OUTSTANDING) && !busy[next_id];
    assign accept     = core_valid && core_ready;
    assign cmp_hit    = cmp_valid && busy[cmp_sb_id];
    assign cmp_miss   = cmp_valid && !busy[cmp_sb_id];

    // Credit pool and sticky error flags.
    always_ff @(posedge clk) begin
        if (!rst_l) begin
            cnt        <= CNT_W'(CREDITS);
            err_sticky <= '0;
        end else begin
            if (cmp_miss)
                err_sticky[0] <= 1'b1;
            if (accept && !vpu_credit) begin
                cnt <= cnt - CNT_W'(1);
            end else if (vpu_credit && !accept) begin
                if (32'(cnt) == CREDITS)
                    err_sticky[1] <= 1'b1;
                else
                    cnt <= cnt + CNT_W'(1);
            end
        end
    end

    // Scoreboard: busy bitmap, outstanding count and id allocation pointer.
    // An accept and a hit never touch the same bit: accept needs next_id free, a hit needs it busy.
    always_ff @(posedge clk) begin
        if (!rst_l) begin
            busy    <= '0;
            out_cnt <= '0;
            next_id <= '0;
        end else begin
            if (cmp_hit)
                busy[cmp_sb_id] <= 1'b0;
            if (accept) begin
                busy[next_id] <= 1'b1;
                next_id       <= next_id + `OVI_SBID_WIDTH'(1);
            end
            if (accept && !cmp_hit)
                out_cnt <= out_cnt + OUT_W'(1);
            else if (cmp_hit && !accept)
                out_cnt <= out_cnt - OUT_W'(1);
        end
    end

    // Registered OVI issue beat; payload holds between beats.
    always_ff @(posedge clk) begin
        if (!rst_l) begin
            vpu_valid       <= 1'b0;
            vpu_instr       <= '0;
            vpu_scalar_opnd <= '0;
            vpu_sb_id       <= '0;
            vpu_vsew        <= '0;
            vpu_vlmul       <= '0;
            vpu_frm         <= '0;
            vpu_vxrm        <= '0;
            vpu_vl          <= '0;
            vpu_vstart      <= '0;
            vpu_vill        <= 1'b0;
        end else begin
            vpu_valid <= accept;
            if (accept) begin
                vpu_instr       <= core_instr;
                vpu_scalar_opnd <= core_scalar;
                vpu_sb_id       <= next_id;
                vpu_vsew        <= core_sew;
                vpu_vlmul       <= cfg_vlmul;
                vpu_frm         <= cfg_frm;
                vpu_vxrm        <= cfg_vxrm;
                vpu_vl          <= core_vl;
                vpu_vstart      <= '0;
                vpu_vill        <= (32'(core_sew) > 3);
            end
        end
    end

    // Completion return to the core, one cycle after a completion for a busy id.
    always_ff @(posedge clk) begin
        if (!rst_l) begin
            core_cmp_valid   <= 1'b0;
            core_cmp_illegal <= 1'b0;
            core_cmp_data    <= '0;
        end else begin
            core_cmp_valid   <= cmp_hit;
            core_cmp_illegal <= cmp_hit && cmp_illegal;
            if (cmp_hit)
                core_cmp_data <= `OVI_DATA_WIDTH'(cmp_dest_reg);
        end
    end

endmodule

// File: doc/ovi_issue_ctrl.md
# ovi_issue_ctrl

Issue scheduler between the SweRV core and the OVI vector unit. It accepts vector instructions from the core issue side and allocates a scoreboard id to each. It meters issue against the VPU's credit pool and drives a registered OVI issue beat with the vector CSR snapshot. It also tracks outstanding scoreboard ids and returns VPU completions to the core.

## Interface
Parameters:
- CREDITS, 4: OVI issue credits granted by the VPU at reset.
- MAX_OUTSTANDING, 8: cap on in-flight sb_ids; must be ≤ 2^`OVI_SBID_WIDTH.

Ports (one clock; reset is synchronous and active-low):
- clk  in  1  clock; all state updates on rising edge.
- rst_l  in  1  synchronous active-low reset.
- core_instr  in  `OVI_INSTR_WIDTH  instruction from core.
- core_vl  in  `OVI_VL_WIDTH  vl for this instruction.
- core_sew  in  `OVI_SEW_WIDTH  sew encoding.
- core_scalar  in  `OVI_SCALAROPND_WIDTH  scalar operand.
- core_valid  in  1  core request.
- core_ready  out  1  block can accept this cycle.
- cfg_vlmul  in  2  current vlmul.
- cfg_frm  in  3  current frm.
- cfg_vxrm  in  2  current vxrm.
- vpu_instr, vpu_scalar_opnd, vpu_sb_id, vpu_vsew, vpu_vlmul, vpu_frm, vpu_vxrm, vpu_vl, vpu_vstart, vpu_vill  out  field widths  OVI issue payload.
- vpu_valid  out  1  OVI issue beat.
- vpu_credit  in  1  one-cycle pulse returning one issue credit.
- cmp_valid  in  1  VPU completion.
- cmp_sb_id  in  `OVI_SBID_WIDTH  completing id.
- cmp_dest_reg  in  `OVI_SCALAROPND_WIDTH  scalar result.
- cmp_illegal  in  1  instruction illegal.
- core_cmp_data  out  `OVI_DATA_WIDTH  result to core (cmp_dest_reg truncated or zero-extended).
- core_cmp_valid  out  1  completion to core.
- core_cmp_illegal  out  1  qualifies core_cmp_valid.
- err_sticky  out  2  bit0 spurious completion, bit1 credit overflow; cleared only by reset.

## Operation
- State:
  - credit counter cnt (0..CREDITS), reset CREDITS.
  - busy bitmap, 2^`OVI_SBID_WIDTH bits, reset 0.
  - outstanding count out_cnt, reset 0.
  - next_id pointer, reset 0.
- core_ready = rst_l && cnt>0 && out_cnt<MAX_OUTSTANDING && !busy[next_id]. Combinational; independent of core_valid.
- Accept (core_valid && core_ready):
  - Register payload into vpu_* with vpu_sb_id=next_id; vpu_vstart=0.
  - vpu_vill=1 when core_sew>3 (reserved encoding); instruction is still issued.
  - Set busy[next_id]; next_id increments, wrapping modulo 2^`OVI_SBID_WIDTH.
  - cnt−1, out_cnt+1.
- Credit:
  - vpu_credit increments cnt.
  - Same-cycle accept and credit leave cnt unchanged.
  - Credit at cnt==CREDITS with no accept: cnt stays, err_sticky[1] set.
- Completion:
  - cmp_valid with busy[cmp_sb_id]=1 clears the bit and decrements out_cnt.
  - Next cycle: core_cmp_valid=1, core_cmp_data=cmp_dest_reg, core_cmp_illegal=cmp_illegal.
  - cmp_valid with busy[cmp_sb_id]=0: ignored, no core_cmp_valid, err_sticky[0] set.
- Same-cycle accept and completion: out_cnt net unchanged. The freed bit is visible in core_ready from the next cycle (no bypass).
- Completions may arrive in any order. If next_id is still busy, issue stalls even when out_cnt<MAX.

## Timing
- Issue latency 1: accept in cycle N gives vpu_valid=1 in N+1 for exactly one cycle (no OVI backpressure; credits guarantee acceptance). Back-to-back accepts give back-to-back beats.
- Completion latency 1: cmp_valid in N gives core_cmp_valid in N+1 for one cycle.
- Credit in N is visible in core_ready in N+1.
- Reset values:
  - vpu_valid, core_cmp_valid, core_cmp_illegal, err_sticky = 0.
  - All vpu_* payload and core_cmp_data = 0.
  - core_ready = 0 while rst_l=0, and 1 the first cycle after release.
- Reset mid-operation: in-flight beats are dropped, busy/ids are cleared, and late completions after reset are flagged spurious.

## Test plan
- Single issue: core_valid with instr=0x0000_5057, vl=16, sew=2 → vpu_valid next cycle, sb_id=0, vill=0, cnt 4→3; cmp_valid sb_id=0, dest=0x55 → core_cmp_valid next cycle with data 0x55.
- Credit exhaustion: CREDITS=4, 5 back-to-back requests and no credits → 4 beats (ids 0–3), core_ready=0 afterward; one vpu_credit pulse → 5th issues 2 cycles later with id 4.
- Out-of-order and wrap: issue 2^`OVI_SBID_WIDTH ids with credits returned, hold id 0 busy, complete the rest → stall at wrap until id 0 completes, then issue id 0 next cycle.
- Simultaneous events: accept, vpu_credit and a valid completion in one cycle → cnt and out_cnt unchanged; busy reflects new id set and old id cleared.
- Errors: completion for non-busy id 7 → no core_cmp_valid, err_sticky=01; credit at full pool → err_sticky=11; sew=5 issue → vpu_vill=1.
- Reset mid-flight: 3 outstanding, assert rst_l=0 for one cycle → all outputs 0, cnt=CREDITS, next id 0.
